nios_fprint_processor3_0_cpu3_mult_seq: RTL and testbench
=========================================================

// Module: nios_fprint_processor3_0_cpu3_mult_seq
// PURPOSE
//  Issue/collect sequencer wrapped around the CPU3 32x32 multiplier cell. Accepts multiply requests over a
//  valid/ready port and drives the cell's operands, sign controls and stage enables (M_en, A_en). Takes the
//  cell's 64-bit registered product, selects the low or high word per opcode, and returns it with a tag
//  through a credit-protected result FIFO. The cell therefore never stalls and never loses a product.
// PARAMETERS
//  TAG_W      5  width of request/response tag (destination register index)
//  RSP_DEPTH  4  result FIFO entries; legal 2..8; >=4 required for 1 op/cycle throughput
// PORTS
//  clk                           in   1     clock
//  reset_n                       in   1     asynchronous active-low reset
//  flush                         in   1     sync kill of all in-flight and queued ops
//  req_valid                     in   1     request valid
//  req_ready                     out  1     request accepted when req_valid&req_ready (req_fire)
//  req_op                        in   2     00 MUL(lo,uu) 01 MULXSS(hi,ss) 10 MULXSU(hi,su) 11 MULXUU(hi,uu)
//  req_src1 / req_src2           in   32    operands
//  req_tag                       in   TAG_W tag returned with result
//  E_src1_mul_cell/E_src2_mul_cell out 32   to cell dataa/datab (= req_src1/req_src2, combinational)
//  E_ctrl_mul_shift_src1_signed  out  1     to cell signa: 1 for MULXSS, MULXSU
//  E_ctrl_mul_shift_src2_signed  out  1     to cell signb: 1 for MULXSS only
//  M_en                          out  1     cell input-register enable
//  A_en                          out  1     cell output-register enable
//  A_mul_cell_result             in   64    cell registered product
//  rsp_valid / rsp_ready         out/in 1   result handshake; pop on rsp_valid&rsp_ready
//  rsp_data                      out  32    selected product word
//  rsp_tag                       out  TAG_W tag of rsp_data
//  busy                          out  1     any op in s1, s2 or FIFO
// BEHAVIOUR
//  - Reset: s1_valid=s2_valid=0, FIFO empty; rsp_valid=0, rsp_data=0, rsp_tag=0, busy=0, M_en=A_en=0.
//  - Credit: occ = s1_valid+s2_valid+fifo_count; req_ready = ~flush & (occ < RSP_DEPTH). No same-cycle credit
//    from a pop.
//  - M_en = req_fire. Cell captures operands/signs at that edge; s1_valid<=1, s1 op/tag <= req op/tag.
//  - A_en = s1_valid. Cell output register captures the product; s2_valid<=s1_valid, s2 op/tag <= s1 op/tag.
//  - s2_valid: write {word,tag} to FIFO at the edge; word = op==00 ? result[31:0] : result[63:32]. Credit
//    guarantees space; a write to a full FIFO is a design error (assertion).
//  - rsp_* driven from the FIFO head (registered). Latency req_fire(cycle t) -> rsp_valid at cycle t+3.
//  - Results return strictly in issue order. rsp_data/rsp_tag hold while rsp_valid & ~rsp_ready.
//  - Simultaneous FIFO write and pop: both take effect; count unchanged. Pop of the last entry plus a write:
//    the new entry is head next cycle.
//  - flush (cycle t): at the edge s1_valid, s2_valid, FIFO count <- 0; rsp_valid=0 from t+1. req_ready=0 in
//    cycle t, so no req_fire. M_en=A_en=0 in cycle t. A pop in cycle t is discarded with the rest.
//  - Cell output register contents after flush are stale but never consumed (no s2_valid).
//  - Async reset mid-operation: all state cleared immediately. The cell is cleared by the same reset_n.
//  - FIFO pointers wrap modulo RSP_DEPTH; count is $clog2(RSP_DEPTH+1) bits wide.
//  - busy = |occ.
// TESTING
//  1. Single MUL 0x0000_0003*0x0000_0005 tag 7, rsp_ready=1 -> rsp_valid at t+3; data 0x0000_000F; tag 7; busy
//     low at t+4.
//  2. MULXSS 0xFFFF_FFFF*0xFFFF_FFFF -> 0x0000_0000. MULXUU same operands -> 0xFFFF_FFFE.
//     MULXSU 0xFFFF_FFFF*0x0000_0002 -> 0xFFFF_FFFF.
//  3. Back-to-back 16 ops, rsp_ready=1, RSP_DEPTH=4 -> req_ready never drops; 16 results in order, one per
//     cycle.
//  4. rsp_ready=0, 6 requests offered -> exactly 4 accepted, req_ready=0 thereafter.
//     Raise rsp_ready -> 4 results in order; req_ready re-asserts the cycle after the first pop.
//  5. flush with ops in s1, s2 and FIFO plus req_valid=1 -> no accept that cycle; rsp_valid=0 next cycle.
//     No stale result ever appears; the next request returns a correct result.
//  6. reset_n low mid-stream for 1 cycle -> all outputs at reset values immediately.
//     After release, the first new op completes at t+3 with a correct result.

Source files
------------

// File: rtl/nios_fprint_processor3_0_cpu3_mult_seq.sv
// Issue/collect sequencer for the CPU3 32x32 multiplier cell.
// Two pipeline stages track the cell; a credit-guarded FIFO returns results.
module nios_fprint_processor3_0_cpu3_mult_seq #(
  parameter int TAG_W     = 5,
  parameter int RSP_DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [31:0]      req_src1,
  input  logic [31:0]      req_src2,
  input  logic [TAG_W-1:0] req_tag,
  output logic [31:0]      E_src1_mul_cell,
  output logic [31:0]      E_src2_mul_cell,
  output logic             E_ctrl_mul_shift_src1_signed,
  output logic             E_ctrl_mul_shift_src2_signed,
  output logic             M_en,
  output logic             A_en,
  input  logic [63:0]      A_mul_cell_result,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_data,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             busy
);

  localparam int PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int CW = $clog2(RSP_DEPTH + 1);
  localparam int OW = $clog2(RSP_DEPTH + 3);

  logic             s1_valid_q, s2_valid_q;
  logic [1:0]       s1_op_q, s2_op_q;
  logic [TAG_W-1:0] s1_tag_q, s2_tag_q;

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [31:0]      data_mem [RSP_DEPTH];
  logic [TAG_W-1:0] tag_mem  [RSP_DEPTH];

  logic [OW-1:0]    occ;
  logic             req_fire;
  logic             wr_en, rd_en;
  logic [31:0]      wr_word;

  // Occupancy counts every op that will eventually need a FIFO slot.
  assign occ = OW'(s1_valid_q) + OW'(s2_valid_q) + OW'(cnt_q);

  assign req_ready = ~flush & (occ < OW'(RSP_DEPTH));
  assign req_fire  = req_valid & req_ready;
  assign busy      = |occ;

  assign E_src1_mul_cell = req_src1;
  assign E_src2_mul_cell = req_src2;
  assign E_ctrl_mul_shift_src1_signed =
    (req_op == 2'b01) | (req_op == 2'b10);
  assign E_ctrl_mul_shift_src2_signed =
    (req_op == 2'b01);

  assign M_en = req_fire;
  assign A_en = s1_valid_q & ~flush;

  assign wr_en   = s2_valid_q & ~flush;
  assign rd_en   = rsp_valid & rsp_ready & ~flush;
  assign wr_word = (s2_op_q == 2'b00) ?
    A_mul_cell_result[31:0] : A_mul_cell_result[63:32];

  assign rsp_valid = (cnt_q != '0);
  assign rsp_data  = rsp_valid ? data_mem[rd_ptr_q] : '0;
  assign rsp_tag   = rsp_valid ? tag_mem[rd_ptr_q]  : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s1_op_q    <= '0;
      s2_op_q    <= '0;
      s1_tag_q   <= '0;
      s2_tag_q   <= '0;
    end else begin
      s1_valid_q <= req_fire;
      s2_valid_q <= s1_valid_q & ~flush;
      if (req_fire) begin
        s1_op_q  <= req_op;
        s1_tag_q <= req_tag;
      end
      if (s1_valid_q) begin
        s2_op_q  <= s1_op_q;
        s2_tag_q <= s1_tag_q;
      end
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (wr_en) begin
        wr_ptr_d = (wr_ptr_q == PW'(RSP_DEPTH - 1)) ?
          '0 : wr_ptr_q + 1'b1;
      end
      if (rd_en) begin
        rd_ptr_d = (rd_ptr_q == PW'(RSP_DEPTH - 1)) ?
          '0 : rd_ptr_q + 1'b1;
      end
      unique case ({wr_en, rd_en})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      data_mem[wr_ptr_q] <= wr_word;
      tag_mem[wr_ptr_q]  <= s2_tag_q;
    end
  end

  // The credit scheme makes an overflowing write unreachable.
  always_ff @(posedge clk) begin
    if (reset_n && wr_en) begin
      assert (cnt_q < CW'(RSP_DEPTH));
    end
  end

endmodule

// File: tb/tb_nios_fprint_processor3_0_cpu3_mult_seq.sv
// Bench for the multiplier sequencer: behavioural cell model,
// table vectors, scoreboard and hand-written corner sequences.
module tb_nios_fprint_processor3_0_cpu3_mult_seq;

  logic        clk = 1'b0;
  logic        reset_n, flush;
  logic        req_valid, req_ready;
  logic [1:0]  req_op;
  logic [31:0] req_src1, req_src2;
  logic [4:0]  req_tag;
  logic [31:0] e_src1, e_src2;
  logic        e_sa, e_sb, M_en, A_en;
  logic [63:0] A_mul_cell_result;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_data;
  logic [4:0]  rsp_tag;
  logic        busy;

  always #5 clk = ~clk;

  nios_fprint_processor3_0_cpu3_mult_seq #(
    .TAG_W(5), .RSP_DEPTH(4)
  ) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_src1(req_src1),
    .req_src2(req_src2), .req_tag(req_tag),
    .E_src1_mul_cell(e_src1), .E_src2_mul_cell(e_src2),
    .E_ctrl_mul_shift_src1_signed(e_sa),
    .E_ctrl_mul_shift_src2_signed(e_sb),
    .M_en(M_en), .A_en(A_en),
    .A_mul_cell_result(A_mul_cell_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_tag(rsp_tag),
    .busy(busy)
  );

  // Multiplier cell: input register on M_en, output register on A_en.
  logic [31:0]        ca_q, cb_q;
  logic               csa_q, csb_q;
  logic [63:0]        cp_q;
  logic signed [65:0] cprod;
  assign cprod = $signed({csa_q & ca_q[31], ca_q})
               * $signed({csb_q & cb_q[31], cb_q});
  assign A_mul_cell_result = cp_q;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ca_q <= '0; cb_q <= '0; csa_q <= 1'b0; csb_q <= 1'b0;
      cp_q <= '0;
    end else begin
      if (M_en) begin
        ca_q <= e_src1; cb_q <= e_src2;
        csa_q <= e_sa;  csb_q <= e_sb;
      end
      if (A_en) cp_q <= cprod[63:0];
    end
  end

  typedef struct packed {
    logic [31:0] d;
    logic [4:0]  t;
  } sb_t;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  tag;
    logic [31:0] exp;
  } vec_t;

  sb_t         sb_q[$];
  sb_t         mon_e;
  vec_t        vecs[10];
  logic [31:0] cur_exp;
  int          n_tests = 0;
  int          n_fail  = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [1:0] op,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
    logic [63:0] ea, eb, p;
    ea = (op == 2'b01 || op == 2'b10) ? {{32{a[31]}}, a} : {32'b0, a};
    eb = (op == 2'b01) ? {{32{b[31]}}, b} : {32'b0, b};
    p  = ea * eb;
    return (op == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  // Scoreboard: push on request fire, pop and compare on response pop.
  always @(negedge clk) begin
    if (reset_n) begin
      if (flush) begin
        sb_q.delete();
      end else begin
        if (rsp_valid && rsp_ready) begin
          if (sb_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_rsp: got data %0h tag %0h, required none",
                     rsp_data, rsp_tag);
          end else begin
            mon_e = sb_q.pop_front();
            chk("rsp_data", {32'b0, rsp_data}, {32'b0, mon_e.d});
            chk("rsp_tag", {59'b0, rsp_tag}, {59'b0, mon_e.t});
          end
        end
        if (req_valid && req_ready)
          sb_q.push_back('{d: cur_exp, t: req_tag});
      end
    end
  end

  task automatic drive(input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] tag);
    req_valid = 1'b1;
    req_op    = op;
    req_src1  = a;
    req_src2  = b;
    req_tag   = tag;
    cur_exp   = model(op, a, b);
  endtask

  // One isolated op with latency and drain checks; pipeline must be empty.
  task automatic issue_one(input logic [1:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [4:0] tag,
                           input logic [31:0] exp);
    @(posedge clk); #1;
    drive(op, a, b, tag);
    cur_exp = exp;
    @(negedge clk);
    chk("accept", {63'b0, req_ready}, 64'd1);
    chk("m_en", {63'b0, M_en}, 64'd1);
    chk("src1_pass", {32'b0, e_src1}, {32'b0, a});
    chk("signa", {63'b0, e_sa}, {63'b0, (op == 2'b01 || op == 2'b10)});
    chk("signb", {63'b0, e_sb}, {63'b0, (op == 2'b01)});
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("lat_t1", {63'b0, rsp_valid}, 64'd0);
    chk("a_en_t1", {63'b0, A_en}, 64'd1);
    @(negedge clk);
    chk("lat_t2", {63'b0, rsp_valid}, 64'd0);
    @(negedge clk);
    chk("lat_t3", {63'b0, rsp_valid}, 64'd1);
    @(negedge clk);
    chk("busy_t4", {63'b0, busy}, 64'd0);
  endtask

  initial begin
    int acc;
    reset_n = 1'b0; flush = 1'b0; rsp_ready = 1'b1;
    req_valid = 1'b0; req_op = '0; req_src1 = '0; req_src2 = '0;
    req_tag = '0; cur_exp = '0;

    vecs[0] = '{2'b00, 32'h0000_0003, 32'h0000_0005, 5'd7,  32'h0000_000F};
    vecs[1] = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1,  32'h0000_0000};
    vecs[2] = '{2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2,  32'hFFFF_FFFE};
    vecs[3] = '{2'b10, 32'hFFFF_FFFF, 32'h0000_0002, 5'd3,  32'hFFFF_FFFF};
    vecs[4] = '{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4,  32'h0000_0001};
    vecs[5] = '{2'b01, 32'h8000_0000, 32'h8000_0000, 5'd5,  32'h4000_0000};
    vecs[6] = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd6,  32'h8000_0000};
    vecs[7] = '{2'b11, 32'h0001_0000, 32'h0001_0000, 5'd31, 32'h0000_0001};
    vecs[8] = '{2'b00, 32'h1234_5678, 32'h0000_0010, 5'd8,  32'h2345_6780};
    vecs[9] = '{2'b01, 32'hFFFF_FFFE, 32'h0000_0003, 5'd9,  32'hFFFF_FFFF};

    #12;
    chk("rst_rsp_valid", {63'b0, rsp_valid}, 64'd0);
    chk("rst_rsp_data", {32'b0, rsp_data}, 64'd0);
    chk("rst_rsp_tag", {59'b0, rsp_tag}, 64'd0);
    chk("rst_busy", {63'b0, busy}, 64'd0);
    chk("rst_en", {62'b0, M_en, A_en}, 64'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;

    foreach (vecs[i])
      issue_one(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].tag, vecs[i].exp);

    // Back-to-back stream: full throughput with depth 4.
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      drive(2'($urandom_range(0, 3)), $urandom, $urandom, 5'(i));
      @(negedge clk);
      chk("b2b_ready", {63'b0, req_ready}, 64'd1);
      if (i >= 3) chk("b2b_rsp_valid", {63'b0, rsp_valid}, 64'd1);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("b2b_tail_valid", {63'b0, rsp_valid}, 64'd1);
    end
    @(negedge clk);
    chk("b2b_busy", {63'b0, busy}, 64'd0);
    chk("b2b_sb_empty", 64'(sb_q.size()), 64'd0);

    // Credit exhaustion with a stalled consumer.
    rsp_ready = 1'b0;
    acc = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      drive(2'(acc % 4), 32'h100 + 32'(acc), 32'h3, 5'(20 + acc));
      @(negedge clk);
      chk("credit_ready", {63'b0, req_ready}, {63'b0, (c < 4)});
      if (req_ready) acc++;
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("credit_full_ready", {63'b0, req_ready}, 64'd0);
    chk("credit_accepted", 64'(acc), 64'd4);
    chk("hold_data", {32'b0, rsp_data}, {32'b0, sb_q[0].d});
    @(negedge clk);
    chk("hold_data2", {32'b0, rsp_data}, {32'b0, sb_q[0].d});
    chk("hold_tag2", {59'b0, rsp_tag}, {59'b0, sb_q[0].t});
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("no_same_cycle_credit", {63'b0, req_ready}, 64'd0);
    @(negedge clk);
    chk("credit_return", {63'b0, req_ready}, 64'd1);
    repeat (4) @(negedge clk);
    chk("credit_busy", {63'b0, busy}, 64'd0);
    chk("credit_sb_empty", 64'(sb_q.size()), 64'd0);

    // Flush with ops in s1, s2 and the FIFO.
    rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      drive(2'b11, 32'hDEAD_0000 + 32'(i), 32'h7, 5'(10 + i));
    end
    @(posedge clk); #1;
    drive(2'b00, 32'h55, 32'h2, 5'd15);
    flush = 1'b1;
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("pre_flush_rsp", {63'b0, rsp_valid}, 64'd1);
    chk("flush_ready", {63'b0, req_ready}, 64'd0);
    chk("flush_en", {62'b0, M_en, A_en}, 64'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    req_valid = 1'b0;
    @(negedge clk);
    chk("flush_rsp_valid", {63'b0, rsp_valid}, 64'd0);
    chk("flush_busy", {63'b0, busy}, 64'd0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("no_stale", {63'b0, rsp_valid}, 64'd0);
    end
    issue_one(2'b10, 32'hFFFF_FFF0, 32'h0000_0100, 5'd17, 32'hFFFF_FFFF);

    // Async reset in the middle of a stream.
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      drive(2'b00, 32'h9 + 32'(i), 32'h9, 5'(25 + i));
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_rsp_valid", {63'b0, rsp_valid}, 64'd0);
    chk("mid_rst_rsp_data", {32'b0, rsp_data}, 64'd0);
    chk("mid_rst_rsp_tag", {59'b0, rsp_tag}, 64'd0);
    chk("mid_rst_busy", {63'b0, busy}, 64'd0);
    chk("mid_rst_en", {62'b0, M_en, A_en}, 64'd0);
    sb_q.delete();
    @(posedge clk); #1;
    reset_n = 1'b1;
    issue_one(2'b00, 32'h0000_0007, 32'h0000_0006, 5'd30, 32'h0000_002A);

    repeat (3) @(negedge clk);
    chk("final_sb_empty", 64'(sb_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
